// File: rtl/fp_seq_pkg.sv
// Shared definitions for the FP issue sequencer: op encodings, FSM states and the
// op-to-latency lookup.
package fp_seq_pkg;

  localparam logic [1:0] OP_ADDF   = 2'd0;
  localparam logic [1:0] OP_CVTF2I = 2'd1;
  localparam logic [1:0] OP_CVTI2F = 2'd2;
  localparam logic [1:0] OP_MULT   = 2'd3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StWb   = 2'd2
  } seq_state_e;

  function automatic int unsigned op_lat(input logic [1:0]  op,
                                         input int unsigned lat_addf,
                                         input int unsigned lat_cvt,
                                         input int unsigned lat_mult);
    int unsigned lat;
    unique case (op)
      OP_ADDF:              lat = lat_addf;
      OP_CVTF2I, OP_CVTI2F: lat = lat_cvt;
      default:              lat = lat_mult;
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/fp_scoreboard.sv
// Pending-destination scoreboard: 32 integer + 32 FP bits indexed by {is_fp, regnum},
// with three issue lookups and two integer-decode lookups.
module fp_scoreboard (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       set_i,
  input  logic [5:0] set_idx_i,
  input  logic       clr_i,
  input  logic [5:0] clr_idx_i,
  input  logic       mask_i,
  input  logic [5:0] rs1_idx_i,
  input  logic [5:0] rs2_idx_i,
  input  logic [5:0] rd_idx_i,
  input  logic       int_chk_i,
  input  logic [4:0] int_rs1_i,
  input  logic [4:0] int_rs2_i,
  output logic       hit_o,
  output logic       int_hit_o
);

  logic [63:0] sb_q, sb_d, sb_eff;

  // Set is applied after clear so a bypassed re-issue to the same register stays pending.
  always_comb begin
    sb_d = sb_q;
    if (clr_i) sb_d[clr_idx_i] = 1'b0;
    if (set_i) sb_d[set_idx_i] = 1'b1;
  end

  always_comb begin
    sb_eff = sb_q;
    if (mask_i) sb_eff[clr_idx_i] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sb_q <= '0;
    else       sb_q <= sb_d;
  end

  assign hit_o     = sb_eff[rs1_idx_i] | sb_eff[rs2_idx_i] | sb_eff[rd_idx_i];
  assign int_hit_o = int_chk_i & (sb_eff[{1'b0, int_rs1_i}] | sb_eff[{1'b0, int_rs2_i}]);

endmodule

// File: rtl/fp_issue_sequencer.sv
// Issue sequencer for the shared multi-cycle FP/multiply unit. Define FP_SEQ_BYPASS_EN to
// allow a new issue in the writeback cycle (result forwarded by the datapath).
module fp_issue_sequencer
  import fp_seq_pkg::*;
#(
  parameter int unsigned LAT_ADDF = 4,
  parameter int unsigned LAT_CVT  = 2,
  parameter int unsigned LAT_MULT = 6,
  parameter int unsigned CNT_W    = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       issue_valid_i,
  input  logic [1:0] issue_op_i,
  input  logic [4:0] issue_rs1_i,
  input  logic [4:0] issue_rs2_i,
  input  logic       issue_rs1_fp_i,
  input  logic       issue_rs2_fp_i,
  input  logic [4:0] issue_rd_i,
  input  logic       issue_rd_fp_i,
  input  logic [4:0] int_rs1_i,
  input  logic [4:0] int_rs2_i,
  input  logic       int_chk_i,
  input  logic       flush_i,
  output logic       stall_o,
  output logic       fpu_start_o,
  output logic [1:0] fpu_op_o,
  output logic       wb_valid_o,
  output logic [4:0] wb_rd_o,
  output logic       wb_fp_o,
  input  logic       wb_ready_i,
  output logic       busy_o
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, lat_m1;
  logic [1:0]       op_q, op_d;
  logic [4:0]       rd_q, rd_d;
  logic             rd_fp_q, rd_fp_d;
  logic             sb_hit, int_hit, wb_fire, struct_haz, mask_clr, accept, set_en;

  assign wb_fire = (state_q == StWb) & wb_ready_i;

`ifdef FP_SEQ_BYPASS_EN
  assign struct_haz = (state_q != StIdle) & ~wb_fire;
  assign mask_clr   = wb_fire;
`else
  assign struct_haz = (state_q != StIdle);
  assign mask_clr   = 1'b0;
`endif

  assign stall_o = ~rst_i & ((issue_valid_i & ~flush_i & (struct_haz | sb_hit)) | int_hit);
  assign accept  = ~rst_i & issue_valid_i & ~flush_i & ~stall_o;
  // Integer r0 is hardwired, so it is never marked pending.
  assign set_en  = accept & (issue_rd_fp_i | (issue_rd_i != 5'd0));
  assign lat_m1  = CNT_W'(op_lat(issue_op_i, LAT_ADDF, LAT_CVT, LAT_MULT) - 1);

  fp_scoreboard u_sb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .set_i     (set_en),
    .set_idx_i ({issue_rd_fp_i, issue_rd_i}),
    .clr_i     (wb_fire),
    .clr_idx_i ({rd_fp_q, rd_q}),
    .mask_i    (mask_clr),
    .rs1_idx_i ({issue_rs1_fp_i, issue_rs1_i}),
    .rs2_idx_i ({issue_rs2_fp_i, issue_rs2_i}),
    .rd_idx_i  ({issue_rd_fp_i, issue_rd_i}),
    .int_chk_i (int_chk_i),
    .int_rs1_i (int_rs1_i),
    .int_rs2_i (int_rs2_i),
    .hit_o     (sb_hit),
    .int_hit_o (int_hit)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      rd_fp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rd_fp_q <= rd_fp_d;
    end
  end

  // Counter holds LAT-1 at launch; leaving EXEC as it reaches 0 puts WB exactly LAT cycles
  // after fpu_start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rd_fp_d = rd_fp_q;
    unique case (state_q)
      StIdle: ;
      StExec: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = StWb;
      end
      StWb:    if (wb_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (accept) begin
      op_d    = issue_op_i;
      rd_d    = issue_rd_i;
      rd_fp_d = issue_rd_fp_i;
      cnt_d   = lat_m1;
      state_d = (lat_m1 == '0) ? StWb : StExec;
    end
  end

  always_comb begin
    fpu_start_o = accept;
    fpu_op_o    = accept ? issue_op_i : op_q;
    wb_valid_o  = (state_q == StWb);
    wb_rd_o     = rd_q;
    wb_fp_o     = rd_fp_q;
    busy_o      = (state_q != StIdle);
  end

endmodule

// File: tb/tb_fp_issue_sequencer.sv
// Directed bench for fp_issue_sequencer; expected writebacks are queued at issue and
// checked against the write port when it fires.
module tb_fp_issue_sequencer;

  localparam logic [1:0] ADDF = 2'd0, CVTF2I = 2'd1, CVTI2F = 2'd2, MULT = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid, issue_rs1_fp, issue_rs2_fp, issue_rd_fp;
  logic [1:0] issue_op;
  logic [4:0] issue_rs1, issue_rs2, issue_rd, int_rs1, int_rs2;
  logic       int_chk, flush, wb_ready;
  logic       stall, fpu_start, wb_valid, wb_fp, busy;
  logic [1:0] fpu_op;
  logic [4:0] wb_rd;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [5:0]  exp_q[$];
  logic [5:0]  wb_exp;

  always #5 clk = ~clk;

  fp_issue_sequencer dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .issue_valid_i  (issue_valid),
    .issue_op_i     (issue_op),
    .issue_rs1_i    (issue_rs1),
    .issue_rs2_i    (issue_rs2),
    .issue_rs1_fp_i (issue_rs1_fp),
    .issue_rs2_fp_i (issue_rs2_fp),
    .issue_rd_i     (issue_rd),
    .issue_rd_fp_i  (issue_rd_fp),
    .int_rs1_i      (int_rs1),
    .int_rs2_i      (int_rs2),
    .int_chk_i      (int_chk),
    .flush_i        (flush),
    .stall_o        (stall),
    .fpu_start_o    (fpu_start),
    .fpu_op_o       (fpu_op),
    .wb_valid_o     (wb_valid),
    .wb_rd_o        (wb_rd),
    .wb_fp_o        (wb_fp),
    .wb_ready_i     (wb_ready),
    .busy_o         (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] fr(input int n);
    return {1'b1, n[4:0]};
  endfunction

  function automatic logic [5:0] ir(input int n);
    return {1'b0, n[4:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    issue_valid = 1'b0;
    flush       = 1'b0;
    int_chk     = 1'b0;
    int_rs1     = 5'd0;
    int_rs2     = 5'd0;
  endtask

  task automatic present(input logic [1:0] op, input logic [5:0] d, input logic [5:0] s1,
                         input logic [5:0] s2);
    issue_valid                 = 1'b1;
    issue_op                    = op;
    {issue_rd_fp, issue_rd}     = d;
    {issue_rs1_fp, issue_rs1}   = s1;
    {issue_rs2_fp, issue_rs2}   = s2;
  endtask

  // Write-port monitor: every handshake must match the oldest accepted issue.
  always @(negedge clk) begin
    if (!rst && wb_valid && wb_ready) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", 64'(exp_q.size()), 64'd1);
      end else begin
        wb_exp = exp_q.pop_front();
        check("wb_dest", {wb_fp, wb_rd}, wb_exp);
      end
    end
  end

  initial begin
    rst = 1'b1;
    quiet();
    wb_ready = 1'b1;
    present(ADDF, fr(0), fr(0), fr(0));
    issue_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_busy", busy, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_stall", stall, 0);
    check("rst_start", fpu_start, 0);
    check("rst_wb_rd", {wb_fp, wb_rd}, 0);
    check("rst_sb", dut.u_sb.sb_q, 0);
    rst = 1'b0;

    // ADDF f3 <- f1,f2: launch cycle 0, writeback cycle 4, idle cycle 5
    tick(); present(ADDF, fr(3), fr(1), fr(2)); #1;
    check("addf_stall", stall, 0);
    check("addf_start", fpu_start, 1);
    check("addf_op", fpu_op, ADDF);
    exp_q.push_back(fr(3));
    tick(); quiet(); #1;
    check("addf_busy", busy, 1);
    check("addf_start_pulse", fpu_start, 0);
    tick(); tick(); #1;
    check("addf_wb_early", wb_valid, 0);
    tick(); #1;
    check("addf_wb_valid", wb_valid, 1);
    check("addf_wb_rd", {wb_fp, wb_rd}, fr(3));
    tick(); #1;
    check("addf_idle", busy, 0);

    // MULT f5, then ADDF reading f5 stalls through writeback
    tick(); present(MULT, fr(5), fr(7), fr(8)); #1;
    check("mult_start", fpu_start, 1);
    check("mult_op", fpu_op, MULT);
    exp_q.push_back(fr(5));
    tick(); present(ADDF, fr(6), fr(5), fr(1)); #1;
    check("raw_stall_c1", stall, 1);
    check("raw_nostart_c1", fpu_start, 0);
    for (int c = 2; c <= 5; c++) begin
      tick(); #1;
      check("raw_stall_exec", stall, 1);
    end
    tick(); #1;
    check("mult_wb_valid", wb_valid, 1);
`ifdef FP_SEQ_BYPASS_EN
    check("raw_bypass_stall", stall, 0);
    check("raw_bypass_start", fpu_start, 1);
`else
    check("raw_stall_wb", stall, 1);
    check("raw_nostart_wb", fpu_start, 0);
    tick(); #1;
    check("raw_release_stall", stall, 0);
    check("raw_release_start", fpu_start, 1);
`endif
    exp_q.push_back(fr(6));
    tick(); quiet(); #1;
    tick(); tick(); #1;
    check("raw_addf_wb_early", wb_valid, 0);
    tick(); #1;
    check("raw_addf_wb", wb_valid, 1);
    tick(); #1;
    check("raw_idle", busy, 0);

    // CVTF2I r7 blocks an integer reader of r7 until written back
    tick(); present(CVTF2I, ir(7), fr(1), fr(2)); #1;
    check("cvt_r7_start", fpu_start, 1);
    exp_q.push_back(ir(7));
    tick(); quiet(); int_chk = 1'b1; int_rs1 = 5'd7; #1;
    check("int_rs1_stall", stall, 1);
    tick(); int_rs1 = 5'd0; int_rs2 = 5'd7; #1;
    check("cvt_r7_wb", wb_valid, 1);
`ifdef FP_SEQ_BYPASS_EN
    check("int_rs2_bypass", stall, 0);
`else
    check("int_rs2_stall", stall, 1);
`endif
    tick(); #1;
    check("int_release", stall, 0);
    check("int_idle", busy, 0);

    // Same with rd = r0: nothing marked, no stall
    tick(); quiet(); present(CVTF2I, ir(0), fr(1), fr(2)); #1;
    check("cvt_r0_start", fpu_start, 1);
    exp_q.push_back(ir(0));
    tick(); quiet(); int_chk = 1'b1; #1;
    check("int_r0_nostall", stall, 0);
    check("int_r0_sb", dut.u_sb.sb_q, 0);
    tick(); #1;
    check("cvt_r0_wb", wb_valid, 1);
    tick(); quiet(); #1;
    check("cvt_r0_idle", busy, 0);

    // CVTI2F f9 held in WB for 3 cycles by wb_ready=0
    tick(); present(CVTI2F, fr(9), ir(4), ir(0)); wb_ready = 1'b0; #1;
    check("cvti_start", fpu_start, 1);
    exp_q.push_back(fr(9));
    tick(); quiet(); #1;
    for (int c = 2; c <= 4; c++) begin
      tick(); #1;
      check("hold_wb_valid", wb_valid, 1);
      check("hold_wb_rd", {wb_fp, wb_rd}, fr(9));
    end
    tick(); wb_ready = 1'b1; #1;
    check("hold_release_valid", wb_valid, 1);
    tick(); present(ADDF, fr(10), fr(9), fr(9)); #1;
    check("hold_cleared_stall", stall, 0);
    check("hold_cleared_start", fpu_start, 1);
    exp_q.push_back(fr(10));
    tick(); quiet(); #1;
    tick(); tick(); tick(); #1;
    check("f10_wb", wb_valid, 1);
    tick(); #1;
    check("f10_idle", busy, 0);

    // Flushed hazarding issue: no stall, no launch, scoreboard untouched
    tick(); present(MULT, fr(12), fr(1), fr(2)); #1;
    check("mult12_start", fpu_start, 1);
    exp_q.push_back(fr(12));
    tick(); present(ADDF, fr(13), fr(12), fr(1)); flush = 1'b1; #1;
    check("flush_stall", stall, 0);
    check("flush_start", fpu_start, 0);
    tick(); flush = 1'b0; #1;
    check("unflush_stall", stall, 1);
    tick(); quiet(); #1;
    tick(); tick(); #1;
    check("mult12_wb_early", wb_valid, 0);
    tick(); #1;
    check("mult12_wb", wb_valid, 1);
    tick(); present(ADDF, fr(13), fr(1), fr(2)); flush = 1'b1; #1;
    check("flush_idle_start", fpu_start, 0);
    check("flush_idle_stall", stall, 0);
    tick(); quiet(); #1;
    check("flush_idle_busy", busy, 0);

    // Reset during EXEC of MULT drops the op
    tick(); present(MULT, fr(14), fr(1), fr(2)); #1;
    check("mult14_start", fpu_start, 1);
    tick(); quiet(); tick(); #1;
    check("mult14_busy", busy, 1);
    rst = 1'b1; #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_sb", dut.u_sb.sb_q, 0);
    tick(); rst = 1'b0; #1;
    check("post_rst_busy", busy, 0);
    for (int c = 0; c < 8; c++) begin
      tick(); #1;
      check("post_rst_no_wb", wb_valid, 0);
    end
    tick(); present(ADDF, fr(14), fr(14), fr(14)); #1;
    check("post_rst_f14_free", stall, 0);
    exp_q.push_back(fr(14));
    tick(); quiet(); #1;
    tick(); tick(); tick(); #1;
    check("post_rst_f14_wb", wb_valid, 1);
    tick(); #1;
    check("queue_drained", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
